// File: rtl/jt12_eg_pkg.sv
// Shared types and constants for the envelope generator slot.
// Holds the phase encoding and the attenuation limits.
// Optional SSG-EG support in the other files is enabled by defining JT12_SSG_EN.
package jt12_eg_pkg;

  typedef enum logic [1:0] {
    ATTACK  = 2'd0,
    DECAY   = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } eg_state_t;

  localparam logic [9:0] ATT_MAX    = 10'h3FF;
  localparam logic [9:0] ATT_SSG_TH = 10'h200;

  // Sustain threshold compared against eg_att[9:5]; sl==15 maps to the top value.
  function automatic logic [4:0] sustain_th(input logic [3:0] sl);
    return {(sl == 4'd15), sl};
  endfunction

endpackage

// File: rtl/jt12_eg_att_upd.sv
// Next-attenuation arithmetic for one envelope update (purely combinational).
// Latency: 0 cycles; the caller decides whether the result is taken.
// SSG-EG 4x decay/sustain increment is present only when JT12_SSG_EN is defined.
module jt12_eg_att_upd
  import jt12_eg_pkg::*;
(
  input  eg_state_t   state,
  input  logic [9:0]  att,
  input  logic [5:0]  rate,
`ifdef JT12_SSG_EN
  input  logic        ssg_en,
`endif
  output logic [9:0]  att_nxt
);

  logic [2:0]  sh;
  logic [10:0] step;
  logic [10:0] diff;
  logic [10:0] sum;

  // Shift from the rate's upper bits, then attack decrement or saturating increment.
  always_comb begin
    sh      = (rate[5:4] == 2'b11) ? {1'b0, rate[3:2]} : 3'd0;
`ifdef JT12_SSG_EN
    if (ssg_en && (state == DECAY || state == SUSTAIN)) begin
      sh = sh + 3'd2;
    end
`endif
    step    = '0;
    diff    = '0;
    sum     = '0;
    att_nxt = att;
    if (state == ATTACK) begin
      // Exponential approach to zero: larger steps while the level is high.
      step    = (11'(att[9:4]) + 11'd1) << sh;
      diff    = {1'b0, att} - step;
      att_nxt = (step > {1'b0, att}) ? 10'd0 : diff[9:0];
    end else begin
      sum     = {1'b0, att} + (11'd1 << sh);
      att_nxt = sum[10] ? ATT_MAX : sum[9:0];
    end
  end

endmodule

// File: rtl/jt12_eg_slot.sv
// Envelope generator for one operator slot: ADSR phase tracking plus TL add.
// Latency: eg_att moves on the enabled tick; eg_out follows one enabled tick later.
// No backpressure; clk_en gates all state. Define JT12_SSG_EN for SSG-EG ports/behaviour.
module jt12_eg_slot
  import jt12_eg_pkg::*;
#(
  parameter int TL_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        keyon,
`ifdef JT12_SSG_EN
  input  logic        ssg_en,
  input  logic        ssg_inv,
`endif
  input  logic [4:0]  ar,
  input  logic [4:0]  d1r,
  input  logic [4:0]  d2r,
  input  logic [3:0]  rr,
  input  logic [3:0]  sl,
  input  logic [6:0]  tl,
  input  logic        step_in,
  input  logic        sum_up_in,
  input  logic [5:0]  rate_in,
  output logic [4:0]  base_rate,
  output logic        attack,
  output logic [1:0]  eg_state,
  output logic [9:0]  eg_att,
  output logic [9:0]  eg_out
);

  eg_state_t   st;
  logic        keyon_last;
  logic        rise;
  logic        fall;
  logic        upd;
  logic [9:0]  att_nxt;
  logic [9:0]  pre_tl;
  logic [10:0] out_sum;
  logic [9:0]  out_sat;

  assign rise     = keyon & ~keyon_last;
  assign fall     = ~keyon & keyon_last;
  assign upd      = step_in & sum_up_in;
  assign attack   = (st == ATTACK);
  assign eg_state = st;

  // Rate handed to the step stage depends only on the current phase.
  always_comb begin
    base_rate = ar;
    unique case (st)
      ATTACK:  base_rate = ar;
      DECAY:   base_rate = d1r;
      SUSTAIN: base_rate = d2r;
      RELEASE: base_rate = {rr, 1'b1};
      default: base_rate = ar;
    endcase
  end

  jt12_eg_att_upd u_att_upd (
    .state   (st),
    .att     (eg_att),
    .rate    (rate_in),
`ifdef JT12_SSG_EN
    .ssg_en  (ssg_en),
`endif
    .att_nxt (att_nxt)
  );

  // Level before TL is added; SSG inversion mirrors it around the SSG threshold.
  always_comb begin
    pre_tl = eg_att;
`ifdef JT12_SSG_EN
    if (ssg_en && ssg_inv && st != RELEASE) begin
      pre_tl = ATT_SSG_TH - eg_att;
    end
`endif
    out_sum = {1'b0, pre_tl} + (11'(tl) << TL_SHIFT);
    out_sat = out_sum[10] ? ATT_MAX : out_sum[9:0];
  end

  // Phase and attenuation state; key edges win over any pending update.
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= RELEASE;
      eg_att     <= ATT_MAX;
      eg_out     <= ATT_MAX;
      keyon_last <= 1'b0;
    end else if (clk_en) begin
      keyon_last <= keyon;
      eg_out     <= out_sat;
      if (rise) begin
        if (rate_in >= 6'd62) begin
          eg_att <= 10'd0;
          st     <= DECAY;
        end else begin
          st     <= ATTACK;
        end
      end else if (fall) begin
        st <= RELEASE;
      end
`ifdef JT12_SSG_EN
      else if (ssg_en && st != RELEASE && eg_att >= ATT_SSG_TH) begin
        st <= ATTACK;
      end
`endif
      else begin
        if (upd) begin
          eg_att <= att_nxt;
        end
        if (st == ATTACK && eg_att == 10'd0) begin
          st <= DECAY;
        end
        if (st == DECAY && eg_att[9:5] >= sustain_th(sl)) begin
          st <= SUSTAIN;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt12_eg_slot.sv
// Self-checking bench for jt12_eg_slot (default build, SSG-EG disabled).
// Vector table, directed envelope sequences, then random stimulus vs a model.
module tb_jt12_eg_slot;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic       keyon;
  logic [4:0] ar, d1r, d2r;
  logic [3:0] rr, sl;
  logic [6:0] tl;
  logic       step_in, sum_up_in;
  logic [5:0] rate_in;
  logic [4:0] base_rate;
  logic       attack;
  logic [1:0] eg_state;
  logic [9:0] eg_att;
  logic [9:0] eg_out;

  int n_checks = 0;
  int n_pass   = 0;

  jt12_eg_slot #(.TL_SHIFT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .keyon     (keyon),
    .ar        (ar),
    .d1r       (d1r),
    .d2r       (d2r),
    .rr        (rr),
    .sl        (sl),
    .tl        (tl),
    .step_in   (step_in),
    .sum_up_in (sum_up_in),
    .rate_in   (rate_in),
    .base_rate (base_rate),
    .attack    (attack),
    .eg_state  (eg_state),
    .eg_att    (eg_att),
    .eg_out    (eg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected base rate for a given phase using the current rate inputs.
  function automatic int exp_base(input int s);
    case (s)
      0:       return int'(ar);
      1:       return int'(d1r);
      2:       return int'(d2r);
      default: return int'(rr) * 2 + 1;
    endcase
  endfunction

  // ---------------- behavioural reference model ----------------
  int m_state, m_att, m_out, m_klast;

  task automatic model_step();
    int sh, d, thr, ns, na;
    bit rise, fall;
    if (rst) begin
      m_state = 3; m_att = 1023; m_out = 1023; m_klast = 0;
    end else if (clk_en) begin
      ns   = m_state;
      na   = m_att;
      rise = keyon && !m_klast;
      fall = !keyon && m_klast;
      sh   = (rate_in / 4 >= 12) ? rate_in / 4 - 12 : 0;
      if (rise) begin
        if (rate_in >= 62) begin na = 0; ns = 1; end
        else ns = 0;
      end else if (fall) begin
        ns = 3;
      end else begin
        if (step_in && sum_up_in) begin
          if (m_state == 0) begin
            d  = (m_att / 16 + 1) * (1 << sh);
            na = (d > m_att) ? 0 : m_att - d;
          end else begin
            na = (m_att + (1 << sh) > 1023) ? 1023 : m_att + (1 << sh);
          end
        end
        if (m_state == 0 && m_att == 0) ns = 1;
        thr = (sl == 15) ? 31 : int'(sl);
        if (m_state == 1 && m_att / 32 >= thr) ns = 2;
      end
      m_out   = (m_att + int'(tl) * 8 > 1023) ? 1023 : m_att + int'(tl) * 8;
      m_state = ns;
      m_att   = na;
      m_klast = keyon;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rst; bit en; bit key; bit stp; bit sum;
    int rate; int tl;
    int st; int att; int out;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(bit r, bit e, bit k, bit s, bit u, int rt, int t,
                              int st, int att, int out);
    vec_t v;
    v.rst = r; v.en = e; v.key = k; v.stp = s; v.sum = u;
    v.rate = rt; v.tl = t; v.st = st; v.att = att; v.out = out;
    return v;
  endfunction

  int exp_att, guard;

  initial begin
    rst = 1'b1; clk_en = 1'b0; keyon = 1'b0;
    ar = 5'd31; d1r = 5'd5; d2r = 5'd3; rr = 4'd7; sl = 4'd4; tl = 7'd0;
    step_in = 1'b0; sum_up_in = 1'b0; rate_in = 6'd0;

    //          rst en key stp sum rate  tl    state att     out
    vt[0]  = mk(1, 0, 0, 0, 0,  0, 'h00,  3, 'h3FF, 'h3FF); // reset with clk_en low
    vt[1]  = mk(0, 1, 0, 0, 0,  0, 'h00,  3, 'h3FF, 'h3FF);
    vt[2]  = mk(0, 1, 1, 0, 0, 62, 'h00,  1, 'h000, 'h3FF); // fast attack rise
    vt[3]  = mk(0, 1, 1, 0, 0,  0, 'h20,  1, 'h000, 'h100);
    vt[4]  = mk(0, 0, 0, 1, 1, 52, 'h20,  1, 'h000, 'h100); // clk_en low: hold
    vt[5]  = mk(0, 1, 1, 1, 1, 52, 'h20,  1, 'h002, 'h100); // decay sh=1
    vt[6]  = mk(0, 1, 1, 1, 1, 52, 'h7F,  1, 'h004, 'h3FA);
    vt[7]  = mk(0, 1, 1, 1, 1, 52, 'h7F,  1, 'h006, 'h3FC);
    vt[8]  = mk(0, 1, 1, 1, 0, 40, 'h7F,  1, 'h006, 'h3FE); // sum_up low: no update
    vt[9]  = mk(0, 1, 1, 1, 1, 40, 'h7F,  1, 'h007, 'h3FE); // sh=0
    vt[10] = mk(0, 1, 0, 1, 1, 40, 'h7F,  3, 'h007, 'h3FF); // keyoff drops update
    vt[11] = mk(0, 1, 0, 1, 1, 63, 'h00,  3, 'h00F, 'h007); // release sh=3
    vt[12] = mk(0, 1, 1, 1, 1, 20, 'h00,  0, 'h00F, 'h00F); // slow rise drops update
    vt[13] = mk(0, 1, 1, 1, 1, 48, 'h00,  0, 'h00E, 'h00F); // attack step of 1

    for (int i = 0; i < 14; i++) begin
      rst = vt[i].rst; clk_en = vt[i].en; keyon = vt[i].key;
      step_in = vt[i].stp; sum_up_in = vt[i].sum;
      rate_in = 6'(vt[i].rate); tl = 7'(vt[i].tl);
      tick();
      check($sformatf("vec%0d state", i), int'(eg_state), vt[i].st);
      check($sformatf("vec%0d att", i), int'(eg_att), vt[i].att);
      check($sformatf("vec%0d out", i), int'(eg_out), vt[i].out);
      check($sformatf("vec%0d base_rate", i), int'(base_rate), exp_base(vt[i].st));
      check($sformatf("vec%0d attack", i), int'(attack), (vt[i].st == 0) ? 1 : 0);
    end

    // ---- attack from silence with rate 40, then decay, sustain, release ----
    rst = 1'b1; clk_en = 1'b1; keyon = 1'b0; step_in = 1'b0; sum_up_in = 1'b0;
    tl = 7'd0; sl = 4'd4; rate_in = 6'd40;
    tick();
    rst = 1'b0;
    tick();
    keyon = 1'b1;
    tick();
    check("attack_entry state", int'(eg_state), 0);
    check("attack_entry att", int'(eg_att), 'h3FF);
    step_in = 1'b1; sum_up_in = 1'b1;
    exp_att = 'h3FF;
    guard = 0;
    while (exp_att != 0 && guard < 300) begin
      exp_att = exp_att - (exp_att / 16 + 1);
      if (exp_att < 0) exp_att = 0;
      tick();
      check("attack_step att", int'(eg_att), exp_att);
      guard++;
    end
    check("attack_bound", (guard < 300) ? 1 : 0, 1);
    check("attack_at_zero state", int'(eg_state), 0);
    tick();
    check("attack_to_decay state", int'(eg_state), 1);
    check("attack_to_decay att", int'(eg_att), 0);

    rate_in = 6'd52;
    exp_att = 0;
    guard = 0;
    while (exp_att < 'h080 && guard < 200) begin
      exp_att += 2;
      tick();
      check("decay_step att", int'(eg_att), exp_att);
      guard++;
    end
    check("decay_at_threshold state", int'(eg_state), 1);
    tick();
    check("sustain_entry state", int'(eg_state), 2);
    check("sustain_entry att", int'(eg_att), 'h082);

    keyon = 1'b0;
    tick();
    check("keyoff state", int'(eg_state), 3);
    check("keyoff att unchanged", int'(eg_att), 'h082);
    rate_in = 6'd63;
    exp_att = 'h082;
    guard = 0;
    while (exp_att < 'h3FF && guard < 200) begin
      exp_att = (exp_att + 8 > 'h3FF) ? 'h3FF : exp_att + 8;
      tick();
      check("release_step att", int'(eg_att), exp_att);
      guard++;
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      check("release_saturate att", int'(eg_att), 'h3FF);
    end

    // ---- TL saturation at eg_att = 0x100 ----
    rst = 1'b1; step_in = 1'b0; sum_up_in = 1'b0;
    tick();
    rst = 1'b0; rate_in = 6'd62;
    tick();
    keyon = 1'b1;
    tick();
    sl = 4'd15; rate_in = 6'd63; step_in = 1'b1; sum_up_in = 1'b1;
    for (int k = 0; k < 32; k++) tick();
    check("tl_setup att", int'(eg_att), 'h100);
    check("tl_setup state", int'(eg_state), 1);
    step_in = 1'b0; tl = 7'h1F;
    tick();
    check("tl_add out", int'(eg_out), 'h1F8);
    tl = 7'h7F;
    tick();
    check("tl_saturate out", int'(eg_out), 'h3FF);

    // ---- random stimulus against the reference model ----
    rst = 1'b1; clk_en = 1'b0;
    model_step();
    tick();
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      clk_en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) keyon = ~keyon;
      step_in   = 1'($urandom);
      sum_up_in = 1'($urandom);
      rate_in   = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(44, 63)) : 6'($urandom);
      ar  = 5'($urandom); d1r = 5'($urandom); d2r = 5'($urandom);
      rr  = 4'($urandom); sl  = 4'($urandom_range(0, 15));
      tl  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
      model_step();
      tick();
      check("rand state", int'(eg_state), m_state);
      check("rand att", int'(eg_att), m_att);
      check("rand out", int'(eg_out), m_out);
      check("rand base_rate", int'(base_rate), exp_base(m_state));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
